otter_iobus_timer: RTL and testbench



---
 rtl/otter_iobus_pkg.sv | 28 ++
 rtl/otter_iobus_timer_if.sv | 24 ++
 rtl/otter_prescaler.sv | 31 +++
 rtl/otter_iobus_timer.sv | 120 ++++++++++++
 tb/tb_otter_iobus_timer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/otter_iobus_pkg.sv
// Shared definitions for OTTER IOBUS peripherals: timer register offsets,
// control-bit positions and the packed control-register layout.
package otter_iobus_pkg;

   // Word offsets within a peripheral's 32-byte window (IOBUS_ADDR[4:2]).
   localparam logic [2:0] TMR_CTRL     = 3'd0;
   localparam logic [2:0] TMR_PRESCALE = 3'd1;
   localparam logic [2:0] TMR_COMPARE  = 3'd2;
   localparam logic [2:0] TMR_COUNT    = 3'd3;
   localparam logic [2:0] TMR_STATUS   = 3'd4;

   localparam int unsigned CTRL_EN          = 0;
   localparam int unsigned CTRL_AUTO_RELOAD = 1;
   localparam int unsigned CTRL_IRQ_EN      = 2;
   localparam int unsigned CTRL_W           = 3;

   // Field order mirrors the CTRL bit indices above (en is bit 0).
   typedef struct packed {
      logic irq_en;
      logic auto_reload;
      logic en;
   } tmr_ctrl_t;

   function automatic logic iobus_hit(input logic [31:0] addr, input logic [31:0] base);
      return addr[31:5] == base[31:5];
   endfunction

endpackage

// File: rtl/otter_iobus_timer_if.sv
// IOBUS signal bundle between the CPU memory stage (master) and a peripheral (slave).
interface otter_iobus_timer_if;
   // No valid/ready pair: IOBUS_WR is a one-cycle write strobe taken at the
   // rising edge; reads are implicit every cycle, with IOBUS_IN returned one
   // cycle after IOBUS_ADDR is presented and zero when the address misses.
   logic [31:0] IOBUS_ADDR;
   logic [31:0] IOBUS_OUT;
   logic        IOBUS_WR;
   logic [31:0] IOBUS_IN;

   modport master (
      output IOBUS_ADDR,
      output IOBUS_OUT,
      output IOBUS_WR,
      input  IOBUS_IN
   );

   modport slave (
      input  IOBUS_ADDR,
      input  IOBUS_OUT,
      input  IOBUS_WR,
      output IOBUS_IN
   );
endinterface

// File: rtl/otter_prescaler.sv
// Programmable clock divider: one-cycle tick every prescale+1 enabled cycles.
module otter_prescaler #(
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                  CLK,
   input  logic                  RESET_N,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic                  clear,
   output logic                  tick
);

   localparam logic [PRESCALE_W-1:0] PCNT_ONE = PRESCALE_W'(1);

   logic [PRESCALE_W-1:0] pcnt;

   // Tick is decoded from the current count so it lines up with the edge
   // that consumes it; a clear on that same edge does not cancel it.
   assign tick = en && (pcnt == prescale);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pcnt <= '0;
      end else if (clear || !en || tick) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PCNT_ONE;
      end
   end

endmodule

// File: rtl/otter_iobus_timer.sv
// IOBUS timer/compare peripheral: decode, register file, count/compare logic,
// registered read data and a level interrupt on compare match.
module otter_iobus_timer
   import otter_iobus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
   parameter int unsigned PRESCALE_W = 16
) (
   input  logic                CLK,
   input  logic                RESET_N,
   otter_iobus_timer_if.slave  bus,
   output logic                INTR
);

   logic                  hit;
   logic [2:0]            offset;
   logic                  wr_hit;
   logic                  wr_ctrl;
   logic                  wr_prescale;
   logic                  wr_compare;
   logic                  wr_count;
   logic                  wr_status;

   tmr_ctrl_t             ctrl;
   logic [PRESCALE_W-1:0] prescale;
   logic [31:0]           compare;
   logic [31:0]           count;
   logic                  match;
   logic [31:0]           rd_q;
   logic [31:0]           rd_data;

   logic                  presc_clear;
   logic                  tick;
   logic [31:0]           cnt_nxt;
   logic                  cmp_hit;
   logic                  unused_addr_lsbs;

   assign unused_addr_lsbs = ^bus.IOBUS_ADDR[1:0];

   assign hit         = iobus_hit(bus.IOBUS_ADDR, BASE_ADDR);
   assign offset      = bus.IOBUS_ADDR[4:2];
   assign wr_hit      = bus.IOBUS_WR && hit;
   assign wr_ctrl     = wr_hit && (offset == TMR_CTRL);
   assign wr_prescale = wr_hit && (offset == TMR_PRESCALE);
   assign wr_compare  = wr_hit && (offset == TMR_COMPARE);
   assign wr_count    = wr_hit && (offset == TMR_COUNT);
   assign wr_status   = wr_hit && (offset == TMR_STATUS);

   // Reprogramming the divide ratio or stopping the timer restarts the prescale phase.
   assign presc_clear = wr_prescale || (wr_ctrl && !bus.IOBUS_OUT[CTRL_EN]);

   otter_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .CLK      (CLK),
      .RESET_N  (RESET_N),
      .en       (ctrl.en),
      .prescale (prescale),
      .clear    (presc_clear),
      .tick     (tick)
   );

   // A CPU write to COUNT on a tick edge overrides the increment and suppresses the compare.
   assign cnt_nxt = count + 32'd1;
   assign cmp_hit = tick && !wr_count && (cnt_nxt == compare);

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         ctrl     <= '0;
         prescale <= '0;
         compare  <= '0;
         count    <= '0;
         match    <= 1'b0;
         rd_q     <= '0;
      end else begin
         if (wr_ctrl) begin
            ctrl <= tmr_ctrl_t'(bus.IOBUS_OUT[CTRL_W-1:0]);
         end
         if (wr_prescale) begin
            prescale <= bus.IOBUS_OUT[PRESCALE_W-1:0];
         end
         if (wr_compare) begin
            compare <= bus.IOBUS_OUT;
         end

         if (wr_count) begin
            count <= bus.IOBUS_OUT;
         end else if (tick) begin
            count <= (cmp_hit && ctrl.auto_reload) ? 32'd0 : cnt_nxt;
         end

         // Set has priority over a same-edge write-1-to-clear.
         if (cmp_hit) begin
            match <= 1'b1;
         end else if (wr_status && bus.IOBUS_OUT[0]) begin
            match <= 1'b0;
         end

         rd_q <= rd_data;
      end
   end

   always_comb begin
      rd_data = '0;
      if (hit) begin
         case (offset)
            TMR_CTRL:     rd_data[CTRL_W-1:0]     = ctrl;
            TMR_PRESCALE: rd_data[PRESCALE_W-1:0] = prescale;
            TMR_COMPARE:  rd_data                 = compare;
            TMR_COUNT:    rd_data                 = count;
            TMR_STATUS:   rd_data[0]              = match;
            default:      rd_data                 = '0;
         endcase
      end
   end

   assign bus.IOBUS_IN = rd_q;
   assign INTR         = match && ctrl.irq_en;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Directed bench for otter_iobus_timer: bus driver tasks, read scoreboard
// with a negedge monitor, and a final summary line.
module tb_otter_iobus_timer;

   localparam logic [31:0] BASE   = 32'h1100_0100;
   localparam logic [31:0] A_CTRL = BASE + 32'h00;
   localparam logic [31:0] A_PRE  = BASE + 32'h04;
   localparam logic [31:0] A_CMP  = BASE + 32'h08;
   localparam logic [31:0] A_CNT  = BASE + 32'h0C;
   localparam logic [31:0] A_STAT = BASE + 32'h10;
   localparam logic [31:0] A_RSV  = BASE + 32'h14;

   // ---------------- clock / reset ----------------
   logic CLK     = 1'b0;
   logic RESET_N = 1'b0;
   logic INTR;

   always #5 CLK = ~CLK;

   otter_iobus_timer_if bus_if ();

   otter_iobus_timer #(
      .BASE_ADDR  (BASE),
      .PRESCALE_W (16)
   ) dut (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .bus     (bus_if.slave),
      .INTR    (INTR)
   );

   // ---------------- scoreboard ----------------
   logic [31:0] exp_q[$];
   string       name_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic        rd_issue   = 1'b0;
   logic        rd_valid_d = 1'b0;

   always @(posedge CLK) rd_valid_d <= rd_issue;

   always @(negedge CLK) begin : monitor
      logic [31:0] e;
      string       n;
      if (rd_valid_d) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_read: IOBUS_IN=%h with empty expected queue", bus_if.IOBUS_IN);
         end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (bus_if.IOBUS_IN !== e) begin
               failures++;
               $display("FAIL %s: IOBUS_IN=%h expected %h", n, bus_if.IOBUS_IN, e);
            end
         end
      end
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge CLK);
      bus_if.IOBUS_ADDR = a;
      bus_if.IOBUS_OUT  = d;
      bus_if.IOBUS_WR   = 1'b1;
      rd_issue          = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string nm);
      @(negedge CLK);
      bus_if.IOBUS_ADDR = a;
      bus_if.IOBUS_WR   = 1'b0;
      rd_issue          = 1'b1;
      exp_q.push_back(exp);
      name_q.push_back(nm);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         bus_if.IOBUS_WR = 1'b0;
         rd_issue        = 1'b0;
      end
   endtask

   task automatic do_reset();
      idle(1);
      @(negedge CLK);
      RESET_N = 1'b0;
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      bus_if.IOBUS_ADDR = '0;
      bus_if.IOBUS_OUT  = '0;
      bus_if.IOBUS_WR   = 1'b0;

      // Reset values
      RESET_N = 1'b0;
      repeat (3) @(negedge CLK);
      RESET_N = 1'b1;
      check("reset_intr", {31'b0, INTR}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         bus_read(BASE + 32'(i * 4), 32'd0, $sformatf("reset_off%0d", i));
      end

      // Auto-reload, PRESCALE=0, COMPARE=3
      do_reset();
      bus_write(A_PRE, 32'd0);
      bus_write(A_CMP, 32'd3);
      bus_write(A_CTRL, 32'h7);
      bus_read(A_CNT, 32'd0, "ar_cnt0");
      bus_read(A_CNT, 32'd1, "ar_cnt1");
      bus_read(A_CNT, 32'd2, "ar_cnt2");
      check("ar_intr_before_match", {31'b0, INTR}, 32'd0);
      bus_read(A_CNT, 32'd0, "ar_cnt3");
      check("ar_intr_after_match", {31'b0, INTR}, 32'd1);
      bus_read(A_CNT, 32'd1, "ar_cnt4");
      bus_read(A_CNT, 32'd2, "ar_cnt5");
      bus_read(A_CNT, 32'd0, "ar_cnt6");
      bus_write(A_CTRL, 32'h4);
      idle(1);
      check("ar_intr_held", {31'b0, INTR}, 32'd1);
      bus_write(A_STAT, 32'd1);
      idle(1);
      check("ar_intr_w1c", {31'b0, INTR}, 32'd0);
      bus_read(A_STAT, 32'd0, "ar_status_cleared");
      bus_read(A_CNT, 32'd2, "ar_cnt_stopped");
      bus_read(A_CTRL, 32'h4, "ar_ctrl");

      // Prescale 3: one tick per 4 cycles
      do_reset();
      bus_write(A_PRE, 32'd3);
      bus_write(A_CMP, 32'h0000_FFFF);
      bus_write(A_CTRL, 32'h1);
      idle(39);
      bus_read(A_CNT, 32'd9, "ps_cnt_39");
      bus_read(A_CNT, 32'd10, "ps_cnt_40");
      bus_read(A_PRE, 32'd3, "ps_prescale");
      bus_read(A_STAT, 32'd0, "ps_status");

      // Free-running wrap through zero up to COMPARE
      do_reset();
      bus_write(A_PRE, 32'd0);
      bus_write(A_CMP, 32'h10);
      bus_write(A_CNT, 32'hFFFF_FFFE);
      bus_write(A_CTRL, 32'h5);
      bus_read(A_CNT, 32'hFFFF_FFFE, "wr_cnt_fffe");
      bus_read(A_CNT, 32'hFFFF_FFFF, "wr_cnt_ffff");
      bus_read(A_CNT, 32'h0, "wr_cnt_wrap0");
      idle(13);
      bus_read(A_CNT, 32'hE, "wr_cnt_e");
      check("wr_intr_e", {31'b0, INTR}, 32'd0);
      bus_read(A_CNT, 32'hF, "wr_cnt_f");
      check("wr_intr_f", {31'b0, INTR}, 32'd0);
      bus_read(A_CNT, 32'h10, "wr_cnt_10");
      check("wr_intr_10", {31'b0, INTR}, 32'd1);
      bus_read(A_CNT, 32'h11, "wr_cnt_11");
      bus_read(A_STAT, 32'd1, "wr_status");

      // Collisions: W1C vs match, COUNT write vs tick
      do_reset();
      bus_write(A_PRE, 32'd0);
      bus_write(A_CMP, 32'd3);
      bus_write(A_CTRL, 32'h3);
      idle(2);
      bus_write(A_STAT, 32'd1);
      bus_read(A_STAT, 32'd1, "col_set_wins");
      bus_read(A_CTRL, 32'h3, "col_ctrl");
      bus_write(A_CNT, 32'h100);
      bus_read(A_CNT, 32'h100, "col_cnt_write");
      bus_read(A_CNT, 32'h101, "col_cnt_next");

      // Misses and reserved offsets
      do_reset();
      bus_write(A_CMP, 32'h1234);
      bus_write(BASE + 32'h40, 32'hDEAD);
      bus_write(BASE + 32'h48, 32'hDEAD);
      bus_write(BASE - 32'h14, 32'hDEAD);
      bus_write(A_RSV, 32'hDEAD);
      bus_read(BASE + 32'h40, 32'd0, "miss_read");
      bus_read(A_CTRL, 32'd0, "miss_ctrl");
      bus_read(A_CMP, 32'h1234, "miss_compare");
      bus_read(A_CNT, 32'd0, "miss_count");
      bus_read(A_RSV, 32'd0, "rsv_read");
      bus_read(A_PRE, 32'd0, "miss_prescale");
      check("miss_intr", {31'b0, INTR}, 32'd0);

      // Asynchronous reset mid-count
      do_reset();
      bus_write(A_PRE, 32'd0);
      bus_write(A_CMP, 32'd2);
      bus_write(A_CTRL, 32'h5);
      bus_read(A_CNT, 32'd0, "ar2_cnt0");
      bus_read(A_CNT, 32'd1, "ar2_cnt1");
      bus_read(A_CNT, 32'd2, "ar2_cnt2");
      bus_read(A_CNT, 32'd3, "ar2_cnt3");
      @(negedge CLK);
      rd_issue = 1'b0;
      check("async_intr_before", {31'b0, INTR}, 32'd1);
      @(posedge CLK);
      #2;
      check("async_rd_before", bus_if.IOBUS_IN, 32'd4);
      RESET_N = 1'b0;
      #1;
      check("async_rd_zero", bus_if.IOBUS_IN, 32'd0);
      check("async_intr_zero", {31'b0, INTR}, 32'd0);
      repeat (2) @(negedge CLK);
      RESET_N = 1'b1;
      bus_read(A_CNT, 32'd0, "async_cnt_after");
      bus_read(A_CTRL, 32'd0, "async_ctrl_after");
      bus_read(A_STAT, 32'd0, "async_status_after");

      // Drain scoreboard
      idle(3);
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d reads never answered, expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
